psr_cond_unit: RTL and testbench

PSR_COND_UNIT -- requirements
Module: psr_cond_unit

---
 rtl/psr_cond_unit.sv | 73 +++++++
 tb/tb_psr_cond_unit.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/psr_cond_unit.sv
// psr_cond_unit: processor status register {N,Z,F,L,C} with masked ALU updates
// and a registered condition evaluator with valid/ack handshake.
// Ports: clk, reset (sync, active-high); flag_we/flag_mask/alu_* update psr;
// cond_req/cond_code/cond_ack drive evaluation, cond_valid/cond_true/busy report it;
// psr_save/psr_restore control the shadow copy of psr.
// Define PSR_SHADOW_EN to build the shadow register; otherwise save/restore are ignored.
module psr_cond_unit #(
  parameter int FLAGS = 5,
  parameter int CCLEN = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flag_we,
  input  logic [FLAGS-1:0] flag_mask,
  input  logic             alu_carry,
  input  logic             alu_low,
  input  logic             alu_overflow,
  input  logic             alu_zero,
  input  logic             alu_negative,
  input  logic             cond_req,
  input  logic [CCLEN-1:0] cond_code,
  input  logic             cond_ack,
  output logic             cond_valid,
  output logic             cond_true,
  output logic             busy,
  output logic [FLAGS-1:0] psr,
  input  logic             psr_save,
  input  logic             psr_restore
);
  typedef enum logic {IDLE, HOLD} state_t;
  state_t state, state_next;
  logic [FLAGS-1:0] alu_vec, psr_upd, psr_next;
  logic [15:0] cond_tab;
  logic n, z, f, l, c, load;
  assign alu_vec = FLAGS'({alu_negative, alu_zero, alu_overflow, alu_low, alu_carry});
  assign psr_upd = flag_we ? (psr & ~flag_mask) | (alu_vec & flag_mask) : psr;
`ifdef PSR_SHADOW_EN
  logic [FLAGS-1:0] shadow;
  assign psr_next = psr_restore ? shadow : psr_upd;
  always_ff @(posedge clk)
    if (reset) shadow <= '0;
    else if (psr_save) shadow <= psr;
`else
  logic unused_shadow_ctl;
  assign unused_shadow_ctl = psr_save ^ psr_restore;
  assign psr_next = psr_upd;
`endif
  // Evaluate on the flags psr will hold after this edge, so a coincident update is seen.
  assign {n, z, f, l, c} = psr_next[4:0];
  assign cond_tab = {1'b0, 1'b1, n | z, ~n & ~z, l | z, ~l & ~z, ~f, f,
                     ~n, n, ~l, l, ~c, c, ~z, z};
  assign load = cond_req & (state == IDLE | cond_ack);
  always_ff @(posedge clk)
    if (reset) state <= IDLE;
    else state <= state_next;
  always_comb begin
    state_next = state;
    if (state == IDLE) state_next = cond_req ? HOLD : IDLE;
    else if (cond_ack) state_next = cond_req ? HOLD : IDLE;
  end
  always_comb begin
    cond_valid = state == HOLD;
    busy = state == HOLD;
  end
  always_ff @(posedge clk)
    if (reset) begin
      psr <= '0;
      cond_true <= 1'b0;
    end else begin
      psr <= psr_next;
      if (load) cond_true <= cond_tab[cond_code];
    end
endmodule

// File: tb/tb_psr_cond_unit.sv
// tb_psr_cond_unit: table-driven check of psr updates, condition decode and handshake.
module tb_psr_cond_unit;
  logic clk = 1'b0, reset = 1'b1, flag_we = 1'b0, cond_req = 1'b0, cond_ack = 1'b0;
  logic [4:0] flag_mask = '0, alu = '0, psr;
  logic [3:0] cond_code = '0;
  logic cond_valid, cond_true, busy, psr_save = 1'b0, psr_restore = 1'b0;
  int checks = 0, errors = 0;
  typedef struct {
    logic we; logic [4:0] m; logic [4:0] a; logic rq; logic [3:0] cc; logic ak;
    logic [4:0] ep; logic ev; logic et;
  } vec_t;
  vec_t tbl[$];
  always #5 clk = ~clk;
  psr_cond_unit dut (
    .clk(clk), .reset(reset), .flag_we(flag_we), .flag_mask(flag_mask),
    .alu_carry(alu[0]), .alu_low(alu[1]), .alu_overflow(alu[2]), .alu_zero(alu[3]),
    .alu_negative(alu[4]), .cond_req(cond_req), .cond_code(cond_code), .cond_ack(cond_ack),
    .cond_valid(cond_valid), .cond_true(cond_true), .busy(busy), .psr(psr),
    .psr_save(psr_save), .psr_restore(psr_restore)
  );
  function automatic vec_t v(logic we, logic [4:0] m, logic [4:0] a, logic rq,
                             logic [3:0] cc, logic ak, logic [4:0] ep, logic ev, logic et);
    v = '{we, m, a, rq, cc, ak, ep, ev, et};
  endfunction
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(logic we, logic [4:0] m, logic [4:0] a, logic rq, logic [3:0] cc,
                       logic ak);
    flag_we = we; flag_mask = m; alu = a; cond_req = rq; cond_code = cc; cond_ack = ak;
  endtask
  initial begin
    tbl.push_back(v(1, 5'b01000, 5'b01000, 0, 0,  0, 5'b01000, 0, 0));
    tbl.push_back(v(0, 5'b00000, 5'b00000, 1, 0,  0, 5'b01000, 1, 1));
    tbl.push_back(v(0, 5'b00000, 5'b00000, 0, 0,  1, 5'b01000, 0, 0));
    tbl.push_back(v(1, 5'b11111, 5'b00000, 0, 0,  0, 5'b00000, 0, 0));
    tbl.push_back(v(1, 5'b10000, 5'b10000, 1, 6,  0, 5'b10000, 1, 1));
    tbl.push_back(v(0, 5'b00000, 5'b00000, 1, 15, 0, 5'b10000, 1, 1));
    tbl.push_back(v(1, 5'b11111, 5'b00000, 1, 15, 0, 5'b00000, 1, 1));
    tbl.push_back(v(0, 5'b00000, 5'b00000, 1, 15, 0, 5'b00000, 1, 1));
    tbl.push_back(v(0, 5'b00000, 5'b00000, 1, 14, 1, 5'b00000, 1, 1));
    tbl.push_back(v(0, 5'b00000, 5'b00000, 0, 0,  1, 5'b00000, 0, 0));
    tbl.push_back(v(0, 5'b00000, 5'b00000, 0, 0,  1, 5'b00000, 0, 0));
    tbl.push_back(v(1, 5'b11111, 5'b00010, 0, 0,  0, 5'b00010, 0, 0));
    tbl.push_back(v(0, 5'b00000, 5'b00000, 1, 10, 0, 5'b00010, 1, 0));
    tbl.push_back(v(0, 5'b00000, 5'b00000, 1, 11, 1, 5'b00010, 1, 1));
    tbl.push_back(v(0, 5'b00000, 5'b00000, 1, 4,  1, 5'b00010, 1, 1));
    tbl.push_back(v(0, 5'b00000, 5'b00000, 1, 5,  1, 5'b00010, 1, 0));
    tbl.push_back(v(1, 5'b11111, 5'b00000, 1, 12, 1, 5'b00000, 1, 1));
    tbl.push_back(v(0, 5'b00000, 5'b00000, 1, 13, 1, 5'b00000, 1, 0));
    tbl.push_back(v(0, 5'b00000, 5'b00000, 1, 3,  1, 5'b00000, 1, 1));
    tbl.push_back(v(0, 5'b00000, 5'b00000, 1, 1,  1, 5'b00000, 1, 1));
    tbl.push_back(v(0, 5'b00000, 5'b00000, 1, 8,  1, 5'b00000, 1, 0));
    tbl.push_back(v(0, 5'b00000, 5'b00000, 1, 15, 1, 5'b00000, 1, 0));
    tbl.push_back(v(0, 5'b00000, 5'b00000, 0, 0,  1, 5'b00000, 0, 0));
    tbl.push_back(v(1, 5'b00101, 5'b11111, 0, 0,  0, 5'b00101, 0, 0));
    tbl.push_back(v(1, 5'b00000, 5'b11111, 0, 0,  0, 5'b00101, 0, 0));
    tbl.push_back(v(0, 5'b11111, 5'b11111, 1, 2,  0, 5'b00101, 1, 1));
    tbl.push_back(v(0, 5'b00000, 5'b00000, 0, 0,  1, 5'b00101, 0, 0));
    drive(1, 5'b11111, 5'b11111, 1, 14, 1);
    step();
    step();
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    chk("reset psr", psr, 5'b0);
    chk("reset valid", cond_valid, 0);
    chk("reset true", cond_true, 0);
    chk("reset busy", busy, 0);
    foreach (tbl[i]) begin
      drive(tbl[i].we, tbl[i].m, tbl[i].a, tbl[i].rq, tbl[i].cc, tbl[i].ak);
      step();
      chk($sformatf("vec%0d psr", i), psr, tbl[i].ep);
      chk($sformatf("vec%0d valid", i), cond_valid, tbl[i].ev);
      chk($sformatf("vec%0d busy", i), busy, tbl[i].ev);
      if (tbl[i].ev) chk($sformatf("vec%0d true", i), cond_true, tbl[i].et);
    end
    drive(0, 0, 0, 1, 14, 0);
    step();
    chk("hold before reset valid", cond_valid, 1);
    reset = 1'b1;
    drive(1, 5'b11111, 5'b11111, 1, 14, 0);
    step();
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    chk("mid-hold reset psr", psr, 5'b0);
    chk("mid-hold reset valid", cond_valid, 0);
    chk("mid-hold reset busy", busy, 0);
    chk("mid-hold reset true", cond_true, 0);
    drive(1, 5'b11111, 5'b00101, 0, 0, 0);
    step();
    drive(0, 0, 0, 0, 0, 0);
    psr_save = 1'b1;
    step();
    psr_save = 1'b0;
    drive(1, 5'b11111, 5'b00000, 0, 0, 0);
    step();
    chk("psr cleared after save", psr, 5'b0);
    drive(0, 0, 0, 0, 0, 0);
    psr_restore = 1'b1;
    step();
`ifdef PSR_SHADOW_EN
    chk("restore", psr, 5'b00101);
`else
    chk("restore ignored", psr, 5'b00000);
`endif
    drive(1, 5'b11111, 5'b11111, 0, 0, 0);
    step();
`ifdef PSR_SHADOW_EN
    chk("restore beats flag_we", psr, 5'b00101);
`else
    chk("flag_we with restore ignored", psr, 5'b11111);
`endif
    psr_restore = 1'b0;
    drive(1, 5'b11111, 5'b10000, 0, 0, 0);
    step();
    drive(0, 0, 0, 0, 0, 0);
    psr_save = 1'b1;
    psr_restore = 1'b1;
    step();
`ifdef PSR_SHADOW_EN
    chk("swap psr", psr, 5'b00101);
`else
    chk("swap ignored", psr, 5'b10000);
`endif
    psr_save = 1'b0;
    step();
`ifdef PSR_SHADOW_EN
    chk("swap shadow", psr, 5'b10000);
`else
    chk("restore still ignored", psr, 5'b10000);
`endif
    psr_restore = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
